regfile_write_scheduler: RTL and testbench
==========================================

# regfile_write_scheduler

Sequences the single write port of the 32x32 register file. After reset it sweeps every register to zero. It then shares the port between two writeback requesters, A (execute result) and B (load result), using round-robin arbitration and a valid/ready handshake. It sits between the writeback stage and the register file's `write_address`/`write_data`/`write_enable` inputs, and drives all three from registers.

## Interface
- `ADDR_W`, 5: register address width; the init sweep covers 2**ADDR_W entries.
- `DATA_W`, 32: write data width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a_valid` input 1: requester A has a write pending.
- `a_addr` input ADDR_W: requester A destination register.
- `a_data` input DATA_W: requester A write data.
- `a_ready` output 1: requester A write accepted this cycle.
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same as the A signals, for requester B.
- `rf_wr_en` output 1: drives the register file `write_enable`.
- `rf_wr_addr` output ADDR_W: drives the register file `write_address`.
- `rf_wr_data` output DATA_W: drives the register file `write_data`.
- `init_done` output 1: high once the zero sweep has completed; stays high until reset.

## Operation
- FSM states:
  - INIT: sweeps all registers to zero.
  - RUN: arbitrates between requesters.
- INIT behaviour:
  - Entered on reset; sweep counter `cnt` (ADDR_W+1 bits) = 0.
  - Each cycle registers `rf_wr_en`=1, `rf_wr_addr`=`cnt[ADDR_W-1:0]`, `rf_wr_data`=0, then `cnt`++.
  - After address 2**ADDR_W-1 has been issued, moves to RUN and sets `init_done`=1.
  - `a_ready` = `b_ready` = 0 throughout INIT.
- RUN arbitration:
  - Combinational; one grant per cycle.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester not granted last. Pointer `last` resets to B, so A wins the first contention.
  - `last` updates only on a grant.
- Handshake:
  - `x_ready` = RUN && grant to x. Ready may depend combinationally on `x_valid`.
  - A transfer occurs when `x_valid` && `x_ready` at a rising edge.
  - The requester holds addr/data stable while valid and not ready.
- Output register:
  - On a transfer, `rf_wr_en`=1 and `rf_wr_addr`/`rf_wr_data` = the granted request.
  - Otherwise `rf_wr_en`=0; addr and data hold their last value.
- Same-address contention: both requests are written in grant order, so the later-granted value persists. No merging and no drop.
- No buffering: the scheduler never accepts a write it cannot issue on the next cycle. There is no full or empty condition.

## Timing
- Reset values: `rf_wr_en`=0, `rf_wr_addr`=0, `rf_wr_data`=0, `init_done`=0, `a_ready`=`b_ready`=0, state=INIT, `cnt`=0, `last`=B.
- INIT length:
  - The first sweep write is presented in the first cycle after `rst_n` deasserts.
  - 2**ADDR_W consecutive cycles with `rf_wr_en`=1, i.e. 32 for ADDR_W=5.
  - `init_done` rises on the edge that registers the final sweep write.
  - The first possible ready is the cycle after that.
- Write latency:
  - A transfer at edge N presents the write on outputs during cycle N..N+1.
  - The register file commits it at edge N+1.
  - A read of that address returns the new data after edge N+1.
- Throughput: one write per cycle sustained. Under continuous dual contention, grants alternate A, B, A, B.
- Reset mid-operation:
  - `rst_n` low immediately forces all outputs to reset values, asynchronously.
  - An in-flight write is lost.
  - A new full INIT sweep runs after release.

## Configuration
- `RF_ZERO_REG_EN`:
  - Defined: address 0 is hardwired to zero. A RUN-state transfer to address 0 is accepted (ready asserted) but produces `rf_wr_en`=0. INIT still writes zero to register 0.
  - Undefined: address 0 is an ordinary register and writes to it are issued normally.

## Test plan
- Reset release, no requests: exactly 32 cycles of `rf_wr_en`=1 with addresses 0..31 and data 0. `init_done`=1 after the 32nd write. All reads return 0.
- Request during INIT: `a_valid`=1, addr 5, data 0xDEADBEEF, held from reset release. `a_ready` stays 0 through the sweep and is first asserted the cycle after `init_done` rises. Register 5 reads 0xDEADBEEF one cycle after the transfer.
- Continuous contention:
  - Stimulus: A writes addresses 1..4 with data 0x10..0x13; B writes 8..11 with data 0x20..0x23; both always valid.
  - Required: grant order A, B, A, B, … with one `rf_wr_en` per cycle.
  - Required: final reads are 1..4 = 0x10..0x13 and 8..11 = 0x20..0x23.
- Same-address contention: A writes addr 7, data 0x1111; B writes addr 7, data 0x2222; `last`=B. A is issued then B, and register 7 finally reads 0x2222.
- Reset mid-operation: `rst_n` pulsed low while `rf_wr_en`=1 in RUN. Outputs go to zero without waiting for a clock edge. A full 32-cycle sweep follows and all registers read 0.
- `RF_ZERO_REG_EN`: A writes addr 0, data 0xFFFFFFFF. With the macro defined, `a_ready`=1, `rf_wr_en`=0 and register 0 reads 0. With it undefined, register 0 reads 0xFFFFFFFF.

Source files
------------

// File: rtl/regfile_write_scheduler_if.sv
// Writeback-to-register-file bus: two valid/ready requesters plus the registered
// write port and init status. master = requester side, slave = scheduler side.
interface regfile_write_scheduler_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              init_done;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rf_wr_en, rf_wr_addr, rf_wr_data, init_done
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rf_wr_en, rf_wr_addr, rf_wr_data, init_done
    );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Register-file write-port scheduler: zero sweep after reset, then round-robin A/B.
// Optional macro RF_ZERO_REG_EN: run-time writes to address 0 are accepted but dropped.
module regfile_write_scheduler #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    regfile_write_scheduler_if.slave    bus
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [ADDR_W:0] SWEEP_LAST = {1'b0, {ADDR_W{1'b1}}};

    logic [0:0]        state_reg;
    logic [ADDR_W:0]   cnt_reg;
    logic              last_b_reg;   // 1: B held the most recent grant
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              init_done_reg;

    logic              grant_a;
    logic              grant_b;
    logic              issue;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_reg == ST_RUN) begin
            if (bus.a_valid && bus.b_valid) begin
                grant_a = last_b_reg;
                grant_b = !last_b_reg;
            end else begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid;
            end
        end
    end

    assign sel_addr = grant_a ? bus.a_addr : bus.b_addr;
    assign sel_data = grant_a ? bus.a_data : bus.b_data;

`ifdef RF_ZERO_REG_EN
    // Register 0 is hardwired: the transfer completes but nothing reaches the array.
    assign issue = (grant_a || grant_b) && (sel_addr != '0);
`else
    assign issue = grant_a || grant_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_INIT;
            cnt_reg       <= '0;
            last_b_reg    <= 1'b1;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            init_done_reg <= 1'b0;
        end else if (state_reg == ST_INIT) begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= cnt_reg[ADDR_W-1:0];
            wr_data_reg <= '0;
            cnt_reg     <= cnt_reg + 1'b1;
            if (cnt_reg == SWEEP_LAST) begin
                state_reg     <= ST_RUN;
                init_done_reg <= 1'b1;
            end
        end else begin
            wr_en_reg <= issue;
            if (issue) begin
                wr_addr_reg <= sel_addr;
                wr_data_reg <= sel_data;
            end
            if (grant_a || grant_b) begin
                last_b_reg <= grant_b;
            end
        end
    end

    assign bus.a_ready    = grant_a;
    assign bus.b_ready    = grant_b;
    assign bus.rf_wr_en   = wr_en_reg;
    assign bus.rf_wr_addr = wr_addr_reg;
    assign bus.rf_wr_data = wr_data_reg;
    assign bus.init_done  = init_done_reg;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Randomized + directed bench for regfile_write_scheduler against a rule-level
// reference model and a behavioural 32x32 register file.
module tb_regfile_write_scheduler;
    logic clk;
    logic rst_n;

    regfile_write_scheduler_if #(.ADDR_W(5), .DATA_W(32)) io ();

    regfile_write_scheduler #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (io.slave)
    );

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The register file being driven: commits on the edge after the write is presented.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (io.rf_wr_en) rf_mem[io.rf_wr_addr] <= io.rf_wr_data;
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_mem [32];
    logic        exp_last_b;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_mem(input string tag);
        for (int r = 0; r < 32; r++) begin
            check_val($sformatf("%s_reg%0d", tag, r), rf_mem[r], exp_mem[r]);
        end
    endtask

    // One cycle of requests; the model decides grants from the arbitration rules.
    task automatic drive_cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                               output logic acc_a, output logic acc_b);
        logic ga, gb, wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        @(negedge clk);
        io.a_valid = av; io.a_addr = aa; io.a_data = ad;
        io.b_valid = bv; io.b_addr = ba; io.b_data = bd;
        ga = 1'b0; gb = 1'b0;
        if (av && bv) begin
            if (exp_last_b) ga = 1'b1; else gb = 1'b1;
        end else if (av) ga = 1'b1;
        else if (bv) gb = 1'b1;
        #1;
        check_val("a_ready", io.a_ready, ga);
        check_val("b_ready", io.b_ready, gb);
        @(posedge clk); #1;
        wa = ga ? aa : ba;
        wd = ga ? ad : bd;
        wr = ga || gb;
        if (ZERO_EN && wa == 5'd0) wr = 1'b0;
        if (ga || gb) exp_last_b = gb;
        if (wr) begin
            exp_addr = wa;
            exp_data = wd;
            exp_mem[wa] = wd;
        end
        check_val("rf_wr_en", io.rf_wr_en, wr);
        check_val("rf_wr_addr", io.rf_wr_addr, exp_addr);
        check_val("rf_wr_data", io.rf_wr_data, exp_data);
        $display("cycle a(v=%0d a=%0d) b(v=%0d a=%0d) grant a=%0d b=%0d wr=%0d addr=%0d data=0x%08h",
                 av, aa, bv, ba, ga, gb, io.rf_wr_en, io.rf_wr_addr, io.rf_wr_data);
        acc_a = ga;
        acc_b = gb;
    endtask

    // Releases reset (caller has rst_n low and inputs set) and checks the full zero sweep.
    task automatic sweep;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            check_val("init_a_ready", io.a_ready, 1'b0);
            check_val("init_b_ready", io.b_ready, 1'b0);
            @(posedge clk); #1;
            check_val("init_wr_en", io.rf_wr_en, 1'b1);
            check_val("init_wr_addr", io.rf_wr_addr, i);
            check_val("init_wr_data", io.rf_wr_data, 32'd0);
            check_val("init_done", io.init_done, (i == 31));
            $display("sweep write addr=%0d init_done=%0d", io.rf_wr_addr, io.init_done);
        end
        exp_last_b = 1'b1;
        exp_addr = 5'd31;
        exp_data = 32'd0;
        for (int r = 0; r < 32; r++) exp_mem[r] = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc_a, acc_b;
        logic pa_v, pb_v;
        logic [4:0] pa_a, pb_a;
        logic [31:0] pa_d, pb_d;
        int ia, ib, guard;

        rst_n = 1'b1;
        io.a_valid = 1'b0; io.a_addr = '0; io.a_data = '0;
        io.b_valid = 1'b0; io.b_addr = '0; io.b_data = '0;
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_wr_en", io.rf_wr_en, 1'b0);
        check_val("rst_wr_addr", io.rf_wr_addr, 32'd0);
        check_val("rst_wr_data", io.rf_wr_data, 32'd0);
        check_val("rst_init_done", io.init_done, 1'b0);
        check_val("rst_a_ready", io.a_ready, 1'b0);
        check_val("rst_b_ready", io.b_ready, 1'b0);

        // Reset release with no requests: 32-write sweep, then idle.
        sweep();
        drive_cycle(0, 0, 0, 0, 0, 0, acc_a, acc_b);
        compare_mem("sweep1");

        // Same-address contention: A first (last=B), then B; B's value persists.
        drive_cycle(1, 7, 32'h1111, 1, 7, 32'h2222, acc_a, acc_b);
        check_val("same_addr_first_is_a", acc_a, 1'b1);
        drive_cycle(0, 0, 0, 1, 7, 32'h2222, acc_a, acc_b);
        drive_cycle(0, 0, 0, 0, 0, 0, acc_a, acc_b);
        check_val("same_addr_reg7", rf_mem[7], 32'h2222);

        // Continuous contention: both valid until each has issued four writes.
        ia = 0; ib = 0; guard = 0;
        while ((ia < 4 || ib < 4) && guard < 20) begin
            drive_cycle(ia < 4, 5'(1 + ia), 32'h10 + ia, ib < 4, 5'(8 + ib), 32'h20 + ib, acc_a, acc_b);
            if (acc_a) ia++;
            if (acc_b) ib++;
            guard++;
        end
        check_val("contention_cycles", guard, 8);
        drive_cycle(0, 0, 0, 0, 0, 0, acc_a, acc_b);
        compare_mem("contention");

        // Randomized traffic; a pending request holds until accepted.
        pa_v = 0; pb_v = 0; pa_a = 0; pb_a = 0; pa_d = 0; pb_d = 0;
        for (int c = 0; c < 200; c++) begin
            drive_cycle(pa_v, pa_a, pa_d, pb_v, pb_a, pb_d, acc_a, acc_b);
            if (acc_a || !pa_v) begin
                pa_v = ($urandom_range(0, 3) != 0);
                pa_a = 5'($urandom_range(0, 31));
                pa_d = $urandom();
            end
            if (acc_b || !pb_v) begin
                pb_v = ($urandom_range(0, 3) != 0);
                pb_a = 5'($urandom_range(0, 31));
                pb_d = $urandom();
            end
        end
        drive_cycle(0, 0, 0, 0, 0, 0, acc_a, acc_b);
        compare_mem("random");

        // Write to address 0.
        drive_cycle(1, 0, 32'hFFFF_FFFF, 0, 0, 0, acc_a, acc_b);
        drive_cycle(0, 0, 0, 0, 0, 0, acc_a, acc_b);
        check_val("zero_reg", rf_mem[0], ZERO_EN ? 32'd0 : 32'hFFFF_FFFF);

        // Reset mid-operation while a write is on the outputs.
        drive_cycle(1, 3, 32'hCAFE_0003, 0, 0, 0, acc_a, acc_b);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_wr_en", io.rf_wr_en, 1'b0);
        check_val("midrst_wr_addr", io.rf_wr_addr, 32'd0);
        check_val("midrst_wr_data", io.rf_wr_data, 32'd0);
        check_val("midrst_init_done", io.init_done, 1'b0);
        io.a_valid = 1'b1; io.a_addr = 5'd5; io.a_data = 32'hDEAD_BEEF;
        io.b_valid = 1'b0;
        sweep();
        // Request held through INIT: first ready is the cycle after init_done.
        drive_cycle(1, 5, 32'hDEAD_BEEF, 0, 0, 0, acc_a, acc_b);
        drive_cycle(0, 0, 0, 0, 0, 0, acc_a, acc_b);
        check_val("reg5_after_init", rf_mem[5], 32'hDEAD_BEEF);
        compare_mem("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
